// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronises and debounces a raw push-button, times
// each press as a dot or dash, and decodes the element sequence into a
// letter index (0=A .. 25=Z) once the key has been released for a gap.
module morse_key_decoder #(
    parameter int TICK_CYCLES    = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int DASH_TICKS     = 250,
    parameter int GAP_TICKS      = 700
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic [4:0] letterNum,
    output logic       letter_valid,
    output logic       letter_err,
    output logic [2:0] elem_count,
    output logic       busy
);

    localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PCW = $clog2(DASH_TICKS + 1);
    localparam int GW  = $clog2(GAP_TICKS + 1);

    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0]  DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [PCW-1:0] DASH_MAX  = PCW'(DASH_TICKS);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [4:0]     NO_LETTER = 5'd26;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic           key_meta_q, key_meta_d, key_s_q, key_s_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick;
    logic [DW-1:0]  db_cnt_q, db_cnt_d;
    logic           key_db_q, key_db_d, key_db_prev_q, key_db_prev_d;
    logic           db_rise, db_fall;
    state_t         state_q, state_d;
    logic [PCW-1:0] press_cnt_q, press_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]     pattern_q, pattern_d;
    logic [2:0]     elem_cnt_q, elem_cnt_d;
    logic [4:0]     letter_num_q, letter_num_d;
    logic           letter_valid_q, letter_valid_d;
    logic           letter_err_q, letter_err_d;
    logic           is_dash;
    logic [4:0]     code;

    // Element sequence to letter index; first element sits in the highest used bit.
    function automatic logic [4:0] decode(input logic [2:0] n, input logic [3:0] p);
        logic [4:0] r;
        r = NO_LETTER;
        case (n)
            3'd1: r = p[0] ? 5'd19 : 5'd4;                              // T E
            3'd2: case (p[1:0])
                      2'b00: r = 5'd8;  2'b01: r = 5'd0;                // I A
                      2'b10: r = 5'd13; default: r = 5'd12;             // N M
                  endcase
            3'd3: case (p[2:0])
                      3'b000: r = 5'd18; 3'b001: r = 5'd20;             // S U
                      3'b010: r = 5'd17; 3'b011: r = 5'd22;             // R W
                      3'b100: r = 5'd3;  3'b101: r = 5'd10;             // D K
                      3'b110: r = 5'd6;  default: r = 5'd14;            // G O
                  endcase
            3'd4: case (p)
                      4'b0000: r = 5'd7;  4'b0001: r = 5'd21;           // H V
                      4'b0010: r = 5'd5;  4'b0100: r = 5'd11;           // F L
                      4'b0110: r = 5'd15; 4'b0111: r = 5'd9;            // P J
                      4'b1000: r = 5'd1;  4'b1001: r = 5'd23;           // B X
                      4'b1010: r = 5'd2;  4'b1011: r = 5'd24;           // C Y
                      4'b1100: r = 5'd25; 4'b1101: r = 5'd16;           // Z Q
                      default: r = NO_LETTER;
                  endcase
            default: r = NO_LETTER;
        endcase
        return r;
    endfunction

    // Synchroniser, 1 ms prescaler and tick-based debouncer next-state.
    always_comb begin
        key_meta_d    = key;
        key_s_d       = key_meta_q;
        key_db_prev_d = key_db_q;
        tick          = (presc_q == PRESC_MAX);
        presc_d       = tick ? '0 : presc_q + 1'b1;
        db_cnt_d      = db_cnt_q;
        key_db_d      = key_db_q;
        if (tick) begin
            if (key_s_q != key_db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    key_db_d = key_s_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    assign db_rise = key_db_q & ~key_db_prev_q;
    assign db_fall = ~key_db_q & key_db_prev_q;

    // Front-end registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q    <= 1'b0;
            key_s_q       <= 1'b0;
            presc_q       <= '0;
            db_cnt_q      <= '0;
            key_db_q      <= 1'b0;
            key_db_prev_q <= 1'b0;
        end else begin
            key_meta_q    <= key_meta_d;
            key_s_q       <= key_s_d;
            presc_q       <= presc_d;
            db_cnt_q      <= db_cnt_d;
            key_db_q      <= key_db_d;
            key_db_prev_q <= key_db_prev_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state plus element buffer, timers and decode results.
    always_comb begin
        state_d        = state_q;
        press_cnt_d    = press_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        pattern_d      = pattern_q;
        elem_cnt_d     = elem_cnt_q;
        letter_num_d   = letter_num_q;
        letter_valid_d = 1'b0;
        letter_err_d   = 1'b0;
        is_dash        = (press_cnt_q >= DASH_MAX);
        code           = decode(elem_cnt_q, pattern_q);
        case (state_q)
            IDLE: begin
                if (db_rise) begin
                    state_d     = PRESS;
                    press_cnt_d = '0;
                end
            end
            PRESS: begin
                if (tick && press_cnt_q != DASH_MAX) press_cnt_d = press_cnt_q + 1'b1;
                if (db_fall) begin
                    // Past four elements the buffer is frozen; count 5 flags overflow.
                    if (elem_cnt_q < 3'd4) pattern_d = {pattern_q[2:0], is_dash};
                    if (elem_cnt_q != 3'd5) elem_cnt_d = elem_cnt_q + 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (tick) gap_cnt_d = gap_cnt_q + 1'b1;
                if (tick && gap_cnt_q == GAP_LAST) begin
                    // Decode takes priority over a simultaneous new press.
                    if (code != NO_LETTER) begin
                        letter_num_d   = code;
                        letter_valid_d = 1'b1;
                    end else begin
                        letter_err_d = 1'b1;
                    end
                    pattern_d   = '0;
                    elem_cnt_d  = '0;
                    gap_cnt_d   = '0;
                    press_cnt_d = '0;
                    state_d     = db_rise ? PRESS : IDLE;
                end else if (db_rise) begin
                    press_cnt_d = '0;
                    state_d     = PRESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt_q    <= '0;
            gap_cnt_q      <= '0;
            pattern_q      <= '0;
            elem_cnt_q     <= '0;
            letter_num_q   <= NO_LETTER;
            letter_valid_q <= 1'b0;
            letter_err_q   <= 1'b0;
        end else begin
            press_cnt_q    <= press_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pattern_q      <= pattern_d;
            elem_cnt_q     <= elem_cnt_d;
            letter_num_q   <= letter_num_d;
            letter_valid_q <= letter_valid_d;
            letter_err_q   <= letter_err_d;
        end
    end

    // FSM outputs.
    always_comb begin
        busy         = (state_q != IDLE);
        letterNum    = letter_num_q;
        letter_valid = letter_valid_q;
        letter_err   = letter_err_q;
        elem_count   = elem_cnt_q;
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with short timing parameters.
`timescale 1ns/1ps
module tb_morse_key_decoder;

    localparam int TC = 4;
    localparam int DOT_T  = 3;
    localparam int DASH_T = 8;
    localparam int SEP_T  = 3;
    localparam int END_T  = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key = 1'b0;
    logic [4:0] letterNum;
    logic       letter_valid;
    logic       letter_err;
    logic [2:0] elem_count;
    logic       busy;

    morse_key_decoder #(
        .TICK_CYCLES(4), .DEBOUNCE_TICKS(2), .DASH_TICKS(5), .GAP_TICKS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .letterNum(letterNum),
        .letter_valid(letter_valid), .letter_err(letter_err),
        .elem_count(elem_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [4:0] elems;      // first element in bit n-1, 1 = dash
        int         exp_valid;
        int         exp_letter;
        int         exp_max;
    } vec_t;

    vec_t vecs[8];

    int nchk = 0;
    int nerr = 0;
    int vld_cnt, err_cnt, both_cnt, max_elem, busy_seen;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        vld_cnt = 0; err_cnt = 0; both_cnt = 0; max_elem = 0; busy_seen = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (letter_valid) vld_cnt++;
        if (letter_err) err_cnt++;
        if (letter_valid && letter_err) both_cnt++;
        if (int'(elem_count) > max_elem) max_elem = int'(elem_count);
        if (busy) busy_seen++;
    endtask

    task automatic hold(input logic lvl, input int ticks);
        key = lvl;
        repeat (ticks * TC) step();
    endtask

    task automatic send_elems(input int n, input logic [4:0] elems);
        for (int i = n - 1; i >= 0; i--) begin
            hold(1'b1, elems[i] ? DASH_T : DOT_T);
            if (i > 0) hold(1'b0, SEP_T);
        end
    endtask

    initial begin
        int bad;
        vecs[0] = '{2, 5'b00001, 1, 0,  2};   // A .-
        vecs[1] = '{1, 5'b00001, 1, 19, 1};   // T -
        vecs[2] = '{3, 5'b00000, 1, 18, 3};   // S ...
        vecs[3] = '{5, 5'b00000, 0, 18, 5};   // five dots: overflow
        vecs[4] = '{4, 5'b00011, 0, 18, 4};   // ..-- not a letter
        vecs[5] = '{4, 5'b01101, 1, 16, 4};   // Q --.-
        vecs[6] = '{3, 5'b00101, 1, 10, 3};   // K -.-
        vecs[7] = '{2, 5'b00010, 1, 13, 2};   // N -.

        // Reset held while the key toggles: outputs stay in reset state.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            key = i[2] ^ i[0];
            @(negedge clk);
            if (letterNum != 5'd26 || letter_valid || letter_err || busy || elem_count != 3'd0)
                bad++;
        end
        check("reset_hold_outputs", bad, 0);
        key = 1'b0;
        check("reset_letterNum", int'(letterNum), 26);
        check("reset_busy", int'(busy), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        clear_mon();
        hold(1'b0, 4);
        check("post_reset_letterNum", int'(letterNum), 26);
        check("post_reset_pulses", vld_cnt + err_cnt, 0);

        // Table-driven letters.
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_elems(vecs[v].n, vecs[v].elems);
            hold(1'b0, END_T);
            check($sformatf("v%0d_valid_pulses", v), vld_cnt, vecs[v].exp_valid);
            check($sformatf("v%0d_err_pulses", v), err_cnt, 1 - vecs[v].exp_valid);
            check($sformatf("v%0d_letterNum", v), int'(letterNum), vecs[v].exp_letter);
            check($sformatf("v%0d_elem_count_max", v), max_elem, vecs[v].exp_max);
            check($sformatf("v%0d_elem_count_end", v), int'(elem_count), 0);
            check($sformatf("v%0d_busy_end", v), int'(busy), 0);
            check($sformatf("v%0d_both_pulses", v), both_cnt, 0);
        end

        // One-tick glitch must not be accepted.
        clear_mon();
        hold(1'b1, 1);
        hold(1'b0, 10);
        check("glitch_busy_seen", busy_seen, 0);
        check("glitch_pulses", vld_cnt + err_cnt, 0);
        check("glitch_elem_count", max_elem, 0);
        check("glitch_letterNum", int'(letterNum), 13);

        // Asynchronous reset during GAP after two elements.
        clear_mon();
        send_elems(2, 5'b00001);
        hold(1'b0, SEP_T);
        check("gap_busy_before_reset", int'(busy), 1);
        check("gap_elem_count_before_reset", int'(elem_count), 2);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_letterNum", int'(letterNum), 26);
        check("async_reset_elem_count", int'(elem_count), 0);
        repeat (3) step();
        @(posedge clk); #2 rst_n = 1'b1;
        hold(1'b0, END_T);
        check("gap_reset_no_pulse", vld_cnt + err_cnt, 0);
        check("gap_reset_letterNum", int'(letterNum), 26);

        // Next letter after reset: E.
        clear_mon();
        send_elems(1, 5'b00000);
        hold(1'b0, END_T);
        check("E_valid_pulses", vld_cnt, 1);
        check("E_err_pulses", err_cnt, 0);
        check("E_letterNum", int'(letterNum), 4);
        check("E_elem_count_end", int'(elem_count), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/morse_key_decoder.md
MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000, clk cycles per 1 ms timing tick.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 10, ticks key must be stable before a level change is accepted.
REQ-003 SHALL have parameter DASH_TICKS, default 250, minimum press length in ticks classified as dash.
REQ-004 SHALL have parameter GAP_TICKS, default 700, release length in ticks that ends a letter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 key  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-009 letterNum  output  5  last decoded letter, 0=A .. 25=Z, 26=none; drives glyph ROM select.
REQ-010 letter_valid  output  1  one-cycle pulse when letterNum is updated.
REQ-011 letter_err  output  1  one-cycle pulse when a finished element sequence is not a letter.
REQ-012 elem_count  output  3  elements captured in current letter, 0..5.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 key SHALL pass a 2-flop synchronizer; key_s is the second flop.
REQ-015 Prescaler SHALL count 0..TICK_CYCLES-1 and assert tick for one cycle at wrap.
REQ-016 Debounced key_db SHALL change only after key_s differs from key_db on DEBOUNCE_TICKS consecutive ticks; any agreeing sample restarts the count.
REQ-017 FSM states SHALL be IDLE, PRESS, GAP.
REQ-018 IDLE: key_db rising -> PRESS, press_cnt=0.
REQ-019 PRESS: press_cnt increments per tick, saturating at DASH_TICKS.
REQ-020 PRESS: key_db falling -> append element (dash if press_cnt>=DASH_TICKS, else dot), gap_cnt=0, -> GAP.
REQ-021 Append SHALL shift pattern left: pattern <= {pattern[2:0], is_dash}; first element ends in highest used bit.
REQ-022 elem_count SHALL increment per append, saturating at 5; 5 means overflow, pattern no longer shifted.
REQ-023 GAP: key_db rising before expiry -> PRESS, press_cnt=0, buffer kept.
REQ-024 GAP: gap_cnt increments per tick; on the tick where gap_cnt reaches GAP_TICKS, decode occurs.
REQ-025 Decode SHALL map (elem_count 1..4, pattern) to standard International Morse A..Z (e.g. A=len2 01, E=len1 0, T=len1 1, O=len3 111, Q=len4 1101).
REQ-026 Valid decode: next edge letterNum<=code, letter_valid=1 for exactly one cycle.
REQ-027 Invalid decode or elem_count=5: letter_err=1 for one cycle, letterNum unchanged.
REQ-028 After decode: pattern=0, elem_count=0, state IDLE.
REQ-029 Gap expiry and key_db rising in same cycle: decode wins, then state PRESS with cleared buffer.
REQ-030 letter_valid and letter_err SHALL never be high together.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, letterNum=26, letter_valid=0, letter_err=0, elem_count=0, busy=0, all counters 0, synchronizer and key_db 0.
REQ-032 Reset mid-letter SHALL discard the buffer and emit no pulse.

Verification (TICK_CYCLES=4, DEBOUNCE_TICKS=2, DASH_TICKS=5, GAP_TICKS=8)
REQ-033 Assert rst_n=0 with key toggling -> letterNum=26, all pulses 0, busy=0 throughout.
REQ-034 Press 3 ticks, release 3, press 8, release 12 -> single letter_valid pulse, letterNum=0 (A), elem_count returns 0.
REQ-035 One 8-tick press then release -> letterNum=19 (T); then three 2-tick-held-past-debounce dots -> letterNum=18 (S).
REQ-036 Five dots -> letter_err pulse, elem_count reached 5, letterNum keeps prior value.
REQ-037 Pattern ..-- -> letter_err; key glitch of 1 tick -> no state change, busy stays 0.
REQ-038 rst_n pulse during GAP after two elements -> no pulse, next letter E decodes letterNum=4.
